// File: rtl/dmem_dump_ctrl_if.sv
// dmem_dump_ctrl_if: MEM-stage, debug-unit and data-memory signals of the dump controller
interface dmem_dump_ctrl_if #(
  parameter int NB_DATA     = 32,
  parameter int NB_MEM_ADDR = 7
);
  logic                   i_pipe_mem_read;
  logic                   i_pipe_mem_write;
  logic                   i_pipe_word_en;
  logic                   i_pipe_halfword_en;
  logic                   i_pipe_byte_en;
  logic [NB_MEM_ADDR-1:0] i_pipe_addr;
  logic [NB_DATA-1:0]     i_pipe_write_data;
  logic                   o_pipe_stall;
  logic                   i_dbg_dump_start;
  logic                   i_dbg_halted;
  logic                   i_dbg_ready;
  logic [NB_DATA-1:0]     o_dbg_data;
  logic                   o_dbg_valid;
  logic                   o_dbg_busy;
  logic                   o_dbg_done;
  logic                   o_mem_read;
  logic                   o_mem_write;
  logic                   o_mem_word_en;
  logic                   o_mem_halfword_en;
  logic                   o_mem_byte_en;
  logic [NB_MEM_ADDR-1:0] o_mem_addr;
  logic [NB_DATA-1:0]     o_mem_write_data;
  logic [NB_DATA-1:0]     i_mem_read_data;
  modport slave (
    input  i_pipe_mem_read, i_pipe_mem_write, i_pipe_word_en, i_pipe_halfword_en, i_pipe_byte_en,
    input  i_pipe_addr, i_pipe_write_data, i_dbg_dump_start, i_dbg_halted, i_dbg_ready, i_mem_read_data,
    output o_pipe_stall, o_dbg_data, o_dbg_valid, o_dbg_busy, o_dbg_done,
    output o_mem_read, o_mem_write, o_mem_word_en, o_mem_halfword_en, o_mem_byte_en, o_mem_addr, o_mem_write_data
  );
  modport master (
    output i_pipe_mem_read, i_pipe_mem_write, i_pipe_word_en, i_pipe_halfword_en, i_pipe_byte_en,
    output i_pipe_addr, i_pipe_write_data, i_dbg_dump_start, i_dbg_halted, i_dbg_ready, i_mem_read_data,
    input  o_pipe_stall, o_dbg_data, o_dbg_valid, o_dbg_busy, o_dbg_done,
    input  o_mem_read, o_mem_write, o_mem_word_en, o_mem_halfword_en, o_mem_byte_en, o_mem_addr, o_mem_write_data
  );
endinterface

// File: rtl/dmem_dump_ctrl.sv
// dmem_dump_ctrl: data-memory port arbiter that passes MEM-stage accesses or dumps all words to the debug unit
module dmem_dump_ctrl #(
  parameter int NB_DATA     = 32,
  parameter int NB_MEM_ADDR = 7,
  parameter int N_WORDS     = 32
) (
  input logic            i_clock,
  input logic            i_reset,
  dmem_dump_ctrl_if.slave bus
);
  localparam int NB_IDX = $clog2(N_WORDS);
  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, SEND, DONE} state_t;
  state_t              state_q, state_d;
  logic [NB_IDX-1:0]   index_q, index_d;
  logic [NB_DATA-1:0]  data_q, data_d;
  logic                idle;
  // state, word index and captured word
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      index_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      data_q  <= data_d;
    end
  end
  // next state and index; the captured word only changes in CAPTURE
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (bus.i_dbg_dump_start && bus.i_dbg_halted) begin
        index_d = '0;
        state_d = ISSUE;
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        data_d  = bus.i_mem_read_data;
        state_d = SEND;
      end
      SEND: if (bus.i_dbg_ready) begin
        state_d = (index_q == NB_IDX'(N_WORDS - 1)) ? DONE : ISSUE;
        index_d = (index_q == NB_IDX'(N_WORDS - 1)) ? index_q : index_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // memory port mux: MEM stage in IDLE, word reads of the dump in ISSUE, otherwise quiet
  always_comb begin
    idle                   = state_q == IDLE;
    bus.o_mem_read         = idle ? bus.i_pipe_mem_read : state_q == ISSUE;
    bus.o_mem_write        = idle & bus.i_pipe_mem_write;
    bus.o_mem_word_en      = idle ? bus.i_pipe_word_en : state_q == ISSUE;
    bus.o_mem_halfword_en  = idle & bus.i_pipe_halfword_en;
    bus.o_mem_byte_en      = idle & bus.i_pipe_byte_en;
    bus.o_mem_addr         = idle ? bus.i_pipe_addr : NB_MEM_ADDR'(index_q) << 2;
    bus.o_mem_write_data   = idle ? bus.i_pipe_write_data : '0;
    bus.o_pipe_stall       = !idle & (bus.i_pipe_mem_read | bus.i_pipe_mem_write);
    bus.o_dbg_data         = data_q;
    bus.o_dbg_valid        = state_q == SEND;
    bus.o_dbg_busy         = state_q == ISSUE || state_q == CAPTURE || state_q == SEND;
    bus.o_dbg_done         = state_q == DONE;
  end
endmodule

// File: tb/tb_dmem_dump_ctrl.sv
// tb_dmem_dump_ctrl: scoreboard bench for the data-memory dump controller
module tb_dmem_dump_ctrl;
  localparam int NB_DATA = 32, NB_MEM_ADDR = 7, N_WORDS = 32;
  logic clk = 0, rst = 1, preload = 0;
  always #5 clk = ~clk;
  dmem_dump_ctrl_if #(.NB_DATA(NB_DATA), .NB_MEM_ADDR(NB_MEM_ADDR)) bus ();
  dmem_dump_ctrl #(.NB_DATA(NB_DATA), .NB_MEM_ADDR(NB_MEM_ADDR), .N_WORDS(N_WORDS)) dut (
    .i_clock(clk), .i_reset(rst), .bus(bus)
  );
  logic [31:0] mem [N_WORDS];
  logic [31:0] exp_q [$];
  logic [6:0]  addr_q [$];
  int n_checks = 0, n_fail = 0, beat_cnt = 0;
  // synchronous memory: read data one cycle after o_mem_read, word writes only
  always @(posedge clk) begin
    if (preload) for (int k = 0; k < N_WORDS; k++) mem[k] <= 32'h100 + k;
    else if (bus.o_mem_write && bus.o_mem_word_en) mem[bus.o_mem_addr[6:2]] <= bus.o_mem_write_data;
    if (bus.o_mem_read) bus.i_mem_read_data <= mem[bus.o_mem_addr[6:2]];
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // monitor: pops expected beats and dump read addresses as the DUT presents them
  always @(negedge clk) if (!rst) begin
    if (bus.o_dbg_valid && bus.i_dbg_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected beat: got %h expected none", bus.o_dbg_data);
      end else check("beat data", bus.o_dbg_data, exp_q.pop_front());
      beat_cnt++;
    end
    if (bus.o_dbg_busy && bus.o_mem_read) begin
      if (addr_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected dump read: got addr %h expected none", bus.o_mem_addr);
      end else check("dump read addr", bus.o_mem_addr, addr_q.pop_front());
    end
    if (bus.o_dbg_valid) check("no read while valid", bus.o_mem_read, 0);
  end
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic push_dump();
    for (int k = 0; k < N_WORDS; k++) begin
      exp_q.push_back(32'h100 + k);
      addr_q.push_back(7'(k * 4));
    end
  endtask
  task automatic pipe_idle();
    bus.i_pipe_mem_read = 0; bus.i_pipe_mem_write = 0; bus.i_pipe_word_en = 0;
    bus.i_pipe_halfword_en = 0; bus.i_pipe_byte_en = 0; bus.i_pipe_addr = 0; bus.i_pipe_write_data = 0;
  endtask
  task automatic start_pulse();
    bus.i_dbg_dump_start = 1; tick(); bus.i_dbg_dump_start = 0;
  endtask
  task automatic wait_done(output int n);
    bit found = 0;
    n = 1;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (bus.o_dbg_done) found = 1; else n++;
    end
    if (!found) begin
      n_checks++; n_fail++;
      $display("FAIL done timeout: got no o_dbg_done expected pulse within 400 cycles");
    end
  endtask
  initial begin
    int n;
    pipe_idle();
    bus.i_dbg_dump_start = 0; bus.i_dbg_halted = 0; bus.i_dbg_ready = 1;
    bus.i_pipe_mem_read = 1; bus.i_pipe_word_en = 1; bus.i_pipe_addr = 7'h24;
    #2;
    check("reset valid", bus.o_dbg_valid, 0);
    check("reset busy", bus.o_dbg_busy, 0);
    check("reset done", bus.o_dbg_done, 0);
    check("reset data", bus.o_dbg_data, 0);
    check("reset passthrough read", bus.o_mem_read, 1);
    check("reset passthrough addr", bus.o_mem_addr, 7'h24);
    tick(); tick(); rst = 0; pipe_idle();
    bus.i_pipe_mem_write = 1; bus.i_pipe_word_en = 1; bus.i_pipe_addr = 7'h08; bus.i_pipe_write_data = 32'hDEADBEEF;
    #1;
    check("pass write", bus.o_mem_write, 1);
    check("pass addr", bus.o_mem_addr, 7'h08);
    check("pass wdata", bus.o_mem_write_data, 32'hDEADBEEF);
    check("pass word_en", bus.o_mem_word_en, 1);
    check("pass stall", bus.o_pipe_stall, 0);
    tick(); pipe_idle();
    preload = 1; tick(); preload = 0;
    bus.i_dbg_halted = 1;
    push_dump(); beat_cnt = 0;
    start_pulse();
    wait_done(n);
    check("done latency", n, 97);
    check("beats full dump", beat_cnt, 32);
    check("queue drained", exp_q.size(), 0);
    tick();
    check("done one cycle", bus.o_dbg_done, 0);
    check("idle after done", bus.o_dbg_busy, 0);
    push_dump(); beat_cnt = 0;
    start_pulse();
    for (int i = 0; i < 50 && beat_cnt < 3; i++) tick();
    bus.i_dbg_ready = 0;
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall valid", bus.o_dbg_valid, 1);
      check("stall data", bus.o_dbg_data, 32'h103);
      check("stall no read", bus.o_mem_read, 0);
    end
    tick(); bus.i_dbg_ready = 1;
    wait_done(n);
    check("beats with backpressure", beat_cnt, 32);
    tick();
    bus.i_dbg_halted = 0;
    bus.i_pipe_mem_read = 1; bus.i_pipe_word_en = 1; bus.i_pipe_addr = 7'h14;
    start_pulse();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("unhalted busy", bus.o_dbg_busy, 0);
      check("unhalted pass read", bus.o_mem_read, 1);
      check("unhalted pass addr", bus.o_mem_addr, 7'h14);
      check("unhalted stall", bus.o_pipe_stall, 0);
    end
    tick(); pipe_idle();
    bus.i_dbg_halted = 1;
    push_dump();
    start_pulse();
    repeat (4) tick();
    bus.i_dbg_halted = 0;
    bus.i_pipe_mem_write = 1; bus.i_pipe_word_en = 1; bus.i_pipe_addr = 7'h10; bus.i_pipe_write_data = 32'h0BAD;
    start_pulse();
    check("mid-dump stall", bus.o_pipe_stall, 1);
    check("mid-dump no write", bus.o_mem_write, 0);
    check("mid-dump wdata", bus.o_mem_write_data, 0);
    check("busy after halt drop", bus.o_dbg_busy, 1);
    pipe_idle();
    repeat (5) tick();
    @(posedge clk); #3 rst = 1;
    #1;
    check("async reset valid", bus.o_dbg_valid, 0);
    check("async reset busy", bus.o_dbg_busy, 0);
    exp_q.delete(); addr_q.delete();
    tick(); rst = 0;
    bus.i_dbg_halted = 1;
    push_dump(); beat_cnt = 0;
    start_pulse();
    wait_done(n);
    check("done latency after reset", n, 97);
    check("beats after reset", beat_cnt, 32);
    check("queue drained after reset", exp_q.size(), 0);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000");
    $fatal(1);
  end
endmodule
